// File: rtl/stream_pattern_gen_pkg.sv
// Shared definitions for the framed multi-channel test pattern generator:
// payload modes, FSM states, header/fill constants and the default LFSR taps.
package stream_pattern_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_CONST = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    GAP     = 2'd3
  } state_t;

  localparam logic [7:0]  HDR_MAGIC     = 8'hA5;
  localparam logic [7:0]  CONST_BYTE    = 8'hA5;
  localparam logic [31:0] DEF_LFSR_POLY = 32'h8020_0003;

  // Low 32 bits of a header word; wider buses zero-pad above this.
  function automatic logic [31:0] header_word(input logic [3:0] ch, input logic [15:0] seq);
    return {HDR_MAGIC, 4'h0, ch, seq};
  endfunction

endpackage

// File: rtl/stream_pattern_gen_if.sv
// Output stream of the pattern generator. A word moves when valid_out && ready_in;
// while valid_out is high and ready_in low, all payload fields hold and valid_out stays high.
interface stream_pattern_gen_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              sof_out;
  logic              eof_out;
  logic [3:0]        ch_out;
  logic              ready_in;

  modport master (
    output data_out, valid_out, sof_out, eof_out, ch_out,
    input  ready_in
  );

  modport slave (
    input  data_out, valid_out, sof_out, eof_out, ch_out,
    output ready_in
  );

endinterface

// File: rtl/stream_lfsr_step.sv
// One step of a right-shifting 32-bit Galois LFSR; the tap mask is folded in
// whenever the bit shifted out is 1, so a nonzero state never reaches zero.
module stream_lfsr_step
  import stream_pattern_gen_pkg::*;
#(
  parameter logic [31:0] POLY = DEF_LFSR_POLY
) (
  input  logic [31:0] state,
  output logic [31:0] state_nx
);

  assign state_nx = state[0] ? ((state >> 1) ^ POLY) : (state >> 1);

endmodule

// File: rtl/stream_pattern_gen.sv
// Framed round-robin test traffic generator (header + BURST_LEN payload + GAP_CYC idle).
// Define STREAM_PATTERN_GEN_ERR_INJECT_EN to add the err_inject_in bit-0 corruption port.
module stream_pattern_gen
  import stream_pattern_gen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          CH_N      = 4,
  parameter int          BURST_LEN = 256,
  parameter int          GAP_CYC   = 0,
  parameter logic [31:0] LFSR_POLY = DEF_LFSR_POLY
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic [1:0]            mode_in,
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
  input  logic                  err_inject_in,
`endif
  stream_pattern_gen_if.master  strm,
  output logic [15:0]           frame_cnt_out,
  output state_t                state_dbg
);

  localparam int CH_IW    = (CH_N > 1) ? $clog2(CH_N) : 1;
  localparam int CH_SLOTS = 2 ** CH_IW;
  localparam int IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int LFSR_REP = (DATA_W + 31) / 32;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CH_IW-1:0] CH_LAST  = CH_IW'(CH_N - 1);

  state_t            state, state_nx;
  mode_t             mode_q;
  logic [CH_IW-1:0]  ch_ptr;
  logic [IDX_W-1:0]  idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [15:0]       frame_cnt;

  logic [DATA_W-1:0] incr_cnt [CH_SLOTS];
  logic [DATA_W-1:0] walk     [CH_SLOTS];
  logic [31:0]       lfsr     [CH_SLOTS];
  logic [15:0]       seq      [CH_SLOTS];

  logic                     xfer;
  logic                     last_word;
  logic                     flip;
  logic [31:0]              lfsr_cur, lfsr_nx;
  logic [LFSR_REP*32-1:0]   lfsr_rep;
  logic [DATA_W-1:0]        pay_word;
  logic [DATA_W-1:0]        hdr_word;

  assign xfer      = strm.valid_out && strm.ready_in;
  assign last_word = (idx == IDX_LAST);
  assign lfsr_cur  = lfsr[ch_ptr];
  assign lfsr_rep  = {LFSR_REP{lfsr_cur}};
  assign hdr_word  = DATA_W'(header_word(4'(ch_ptr), seq[ch_ptr]));

  assign frame_cnt_out = frame_cnt;
  assign state_dbg     = state;

  stream_lfsr_step #(.POLY(LFSR_POLY)) u_lfsr_step (
    .state    (lfsr_cur),
    .state_nx (lfsr_nx)
  );

  always_comb begin
    pay_word = '0;
    case (mode_q)
      MODE_INCR: pay_word = incr_cnt[ch_ptr];
      MODE_LFSR: pay_word = lfsr_rep[DATA_W-1:0];
      MODE_WALK: pay_word = walk[ch_ptr];
      default:   pay_word = {(DATA_W/8){CONST_BYTE}};
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    strm.valid_out = 1'b0;
    strm.sof_out   = 1'b0;
    strm.eof_out   = 1'b0;
    strm.ch_out    = 4'h0;
    strm.data_out  = '0;
    case (state)
      IDLE: begin
        if (enable_in) state_nx = HEADER;
      end
      HEADER: begin
        strm.valid_out = 1'b1;
        strm.sof_out   = 1'b1;
        strm.ch_out    = 4'(ch_ptr);
        strm.data_out  = hdr_word;
        if (xfer) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        strm.valid_out = 1'b1;
        strm.eof_out   = last_word;
        strm.ch_out    = 4'(ch_ptr);
        strm.data_out  = pay_word ^ DATA_W'(flip);
        if (xfer && last_word) begin
          if (GAP_CYC > 0)    state_nx = GAP;
          else if (enable_in) state_nx = HEADER;
          else                state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = enable_in ? HEADER : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Mode is latched on every entry into HEADER so it stays frozen for the whole frame.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mode_q    <= MODE_INCR;
      ch_ptr    <= '0;
      idx       <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      for (int c = 0; c < CH_SLOTS; c++) begin
        incr_cnt[c] <= '0;
        walk[c]     <= DATA_W'(1);
        lfsr[c]     <= 32'(c + 1);
        seq[c]      <= '0;
      end
    end else begin
      if (state_nx == HEADER && state != HEADER) mode_q <= mode_t'(mode_in);
      case (state)
        HEADER: begin
          if (xfer) idx <= '0;
        end
        PAYLOAD: begin
          if (xfer) begin
            idx <= idx + 1'b1;
            case (mode_q)
              MODE_INCR: incr_cnt[ch_ptr] <= incr_cnt[ch_ptr] + 1'b1;
              MODE_LFSR: lfsr[ch_ptr]     <= lfsr_nx;
              MODE_WALK: walk[ch_ptr]     <= {walk[ch_ptr][DATA_W-2:0], walk[ch_ptr][DATA_W-1]};
              default: ;
            endcase
            if (last_word) begin
              seq[ch_ptr] <= seq[ch_ptr] + 16'd1;
              frame_cnt   <= frame_cnt + 16'd1;
              ch_ptr      <= (ch_ptr == CH_LAST) ? '0 : ch_ptr + 1'b1;
              gap_cnt     <= '0;
            end
          end
        end
        GAP: gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
  // A pulse parks in err_pend; it becomes err_hot only when no payload word is
  // stalled, so a held word never changes under backpressure.
  logic err_pend, err_hot;
  logic payload_stall;

  assign payload_stall = (state == PAYLOAD) && !strm.ready_in;
  assign flip          = err_hot;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      err_pend <= 1'b0;
      err_hot  <= 1'b0;
    end else begin
      if (err_hot) begin
        if (state == PAYLOAD && xfer) err_hot <= 1'b0;
      end else if (err_pend && !payload_stall) begin
        err_hot  <= 1'b1;
        err_pend <= 1'b0;
      end
      if (err_inject_in && !err_pend && !err_hot) err_pend <= 1'b1;
    end
  end
`else
  assign flip = 1'b0;
`endif

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed bench: one generator without gap (round-robin, backpressure, modes)
// and one with GAP_CYC=3 (gap length and enable drop).
module tb_stream_pattern_gen;
  import stream_pattern_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en0, en1;
  logic [1:0]  md0, md1;
  logic [15:0] fc0, fc1;
  state_t      st0, st1;
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
  logic        err0, err1;
`endif

  int checks = 0;
  int errors = 0;
  bit stall_en = 1'b0;
  logic [37:0] exp_q[$];

  stream_pattern_gen_if #(.DATA_W(32)) s0 ();
  stream_pattern_gen_if #(.DATA_W(32)) s1 ();

  always #5 clk = ~clk;

  stream_pattern_gen #(.DATA_W(32), .CH_N(4), .BURST_LEN(4), .GAP_CYC(0)) dut0 (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .enable_in     (en0),
    .mode_in       (md0),
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    .err_inject_in (err0),
`endif
    .strm          (s0),
    .frame_cnt_out (fc0),
    .state_dbg     (st0)
  );

  stream_pattern_gen #(.DATA_W(32), .CH_N(4), .BURST_LEN(4), .GAP_CYC(3)) dut1 (
    .clk_in        (clk),
    .rst_in        (rst_n),
    .enable_in     (en1),
    .mode_in       (md1),
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    .err_inject_in (err1),
`endif
    .strm          (s1),
    .frame_cnt_out (fc1),
    .state_dbg     (st1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] word_of(input int s);
    if (s == 1) return {s1.sof_out, s1.eof_out, s1.ch_out, s1.data_out};
    return {s0.sof_out, s0.eof_out, s0.ch_out, s0.data_out};
  endfunction

  function automatic logic valid_of(input int s);
    return (s == 1) ? s1.valid_out : s0.valid_out;
  endfunction

  task automatic set_ready(input int s, input logic v);
    if (s == 1) s1.ready_in = v;
    else        s0.ready_in = v;
  endtask

  function automatic logic [37:0] hdr(input int ch, input int sq);
    logic [3:0]  c = 4'(ch);
    logic [15:0] q = 16'(sq);
    return {1'b1, 1'b0, c, 8'hA5, 4'h0, c, q};
  endfunction

  function automatic logic [37:0] pay(input int ch, input logic [31:0] d, input logic last);
    logic [3:0] c = 4'(ch);
    return {1'b0, last, c, d};
  endfunction

  task automatic push_incr(input int f);
    int ch = f % 4;
    int sq = f / 4;
    exp_q.push_back(hdr(ch, sq));
    for (int k = 0; k < 4; k++) exp_q.push_back(pay(ch, 32'(sq * 4 + k), k == 3));
  endtask

  task automatic push_const(input int ch, input int sq);
    exp_q.push_back(hdr(ch, sq));
    for (int k = 0; k < 4; k++) exp_q.push_back(pay(ch, 32'hA5A5_A5A5, k == 3));
  endtask

  // Receive n words from generator s against the expected queue, optionally stalling first.
  task automatic drain(input int s, input int n);
    logic [37:0] snap, exp;
    int k, t;
    for (int i = 0; i < n; i++) begin
      if (stall_en && valid_of(s)) begin
        k = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
        if (k > 0) begin
          set_ready(s, 1'b0);
          snap = word_of(s);
          repeat (k) begin
            step();
            chk("stall_hold", 64'(word_of(s)), 64'(snap));
            chk("stall_valid", 64'(valid_of(s)), 64'd1);
          end
          set_ready(s, 1'b1);
        end
      end
      t = 0;
      while (!valid_of(s) && t < 100) begin
        step();
        t++;
      end
      checks++;
      assert (t < 100) else begin
        errors++;
        $error("FAIL recv_timeout: waited=%0d cycles limit=100", t);
      end
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 38'h0;
      chk("stream_word", 64'(word_of(s)), 64'(exp));
      step();
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    md0 = 2'd0; md1 = 2'd0;
`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    err0 = 1'b0; err1 = 1'b0;
`endif
    s0.ready_in = 1'b0;
    s1.ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 64'(s0.data_out), 64'd0);
    chk("rst_valid", 64'({s1.valid_out, s0.valid_out}), 64'd0);
    rst_n = 1'b1;

    // Idle with enable low.
    for (int i = 0; i < 20; i++) begin
      chk("idle_valid", 64'({s1.valid_out, s0.valid_out}), 64'd0);
      chk("idle_fcnt", 64'({fc1, fc0}), 64'd0);
      step();
    end
    chk("idle_state", 64'(st0), 64'(IDLE));

    // INCR round-robin, 8 frames, ready high.
    s0.ready_in = 1'b1;
    md0 = 2'd0;
    en0 = 1'b1;
    step();
    chk("hdr_latency_valid", 64'(s0.valid_out), 64'd1);
    chk("hdr_latency_sof", 64'(s0.sof_out), 64'd1);
    for (int f = 0; f < 8; f++) push_incr(f);
    drain(0, 40);
    chk("fcnt_8", 64'(fc0), 64'd8);

    // Same stream continued under random backpressure, enable dropped in frame 15.
    stall_en = 1'b1;
    for (int f = 8; f < 16; f++) push_incr(f);
    drain(0, 36);
    en0 = 1'b0;
    drain(0, 4);
    stall_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("drop_idle_valid", 64'(s0.valid_out), 64'd0);
      step();
    end
    chk("fcnt_16", 64'(fc0), 64'd16);
    chk("drop_state", 64'(st0), 64'(IDLE));

    // WALK on ch0, mode switched mid-frame to CONST (applies from frame 17).
    md0 = 2'd2;
    en0 = 1'b1;
    exp_q.push_back(hdr(0, 4));
    exp_q.push_back(pay(0, 32'h1, 1'b0));
    exp_q.push_back(pay(0, 32'h2, 1'b0));
    exp_q.push_back(pay(0, 32'h4, 1'b0));
    exp_q.push_back(pay(0, 32'h8, 1'b1));
    drain(0, 3);
    md0 = 2'd3;
    drain(0, 2);
    push_const(1, 4);
    push_const(2, 4);
    push_const(3, 4);
    drain(0, 11);
    md0 = 2'd1;
    drain(0, 4);

    // LFSR on ch0 from seed 1.
    exp_q.push_back(hdr(0, 5));
    exp_q.push_back(pay(0, 32'h0000_0001, 1'b0));
    exp_q.push_back(pay(0, 32'h8020_0003, 1'b0));
    exp_q.push_back(pay(0, 32'hC030_0002, 1'b0));
    exp_q.push_back(pay(0, 32'h6018_0001, 1'b1));
    drain(0, 1);
    en0 = 1'b0;
    drain(0, 4);
    step();
    chk("mode_idle_valid", 64'(s0.valid_out), 64'd0);
    chk("fcnt_21", 64'(fc0), 64'd21);

    // GAP_CYC=3 generator: gap length, then enable drop at payload word 1.
    md1 = 2'd0;
    s1.ready_in = 1'b1;
    en1 = 1'b1;
    exp_q.push_back(hdr(0, 0));
    for (int k = 0; k < 4; k++) exp_q.push_back(pay(0, 32'(k), k == 3));
    drain(1, 5);
    t = 0;
    while (!s1.valid_out && t < 20) begin
      t++;
      step();
    end
    chk("gap_len", 64'(t), 64'd3);
    exp_q.push_back(hdr(1, 0));
    for (int k = 0; k < 4; k++) exp_q.push_back(pay(1, 32'(k), k == 3));
    drain(1, 2);
    en1 = 1'b0;
    drain(1, 3);
    for (int i = 0; i < 8; i++) begin
      chk("gap_drop_valid", 64'(s1.valid_out), 64'd0);
      step();
    end
    chk("gap_drop_state", 64'(st1), 64'(IDLE));
    chk("gap_fcnt", 64'(fc1), 64'd2);

`ifdef STREAM_PATTERN_GEN_ERR_INJECT_EN
    // Two pulses, one corrupted word: ch1 INCR counter is at 16, so 16 goes out as 17.
    err0 = 1'b1; step();
    err0 = 1'b0; step();
    err0 = 1'b1; step();
    err0 = 1'b0;
    md0 = 2'd0;
    en0 = 1'b1;
    exp_q.push_back(hdr(1, 5));
    exp_q.push_back(pay(1, 32'd17, 1'b0));
    exp_q.push_back(pay(1, 32'd17, 1'b0));
    exp_q.push_back(pay(1, 32'd18, 1'b0));
    exp_q.push_back(pay(1, 32'd19, 1'b1));
    drain(0, 1);
    en0 = 1'b0;
    drain(0, 4);
    step();
    chk("err_fcnt", 64'(fc0), 64'd22);
`endif

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_pattern_gen.md
Name: stream_pattern_gen

Overview:
- Parametrised successor to the single-stream test data generator that feeds the USB FIFO gateway.
- Produces framed test traffic for CH_N logical channels, serviced round-robin.
- Frame format: one header word, then BURST_LEN payload words, then an optional idle gap.
- Payload pattern is selectable per frame; output uses a valid/ready handshake with full backpressure, in place of the old free-running trigger.

Parameters:
- DATA_W, 32: output word width; must be ≥ 32 and a multiple of 8.
- CH_N, 4: number of logical channels; range 1..16.
- BURST_LEN, 256: payload words per frame; must be ≥ 1.
- GAP_CYC, 0: idle cycles inserted after each frame.
- LFSR_POLY, 32'h8020_0003: Galois LFSR tap mask.

Ports:
- clk_in  input  1  generator clock (80 MHz domain)
- rst_in  input  1  asynchronous active-low reset
- enable_in  input  1  level; start and keep generating frames
- mode_in  input  2  payload mode: 0 INCR, 1 LFSR, 2 WALK, 3 CONST
- ready_in  input  1  downstream can accept (typically !full)
- data_out  output  DATA_W  stream word
- valid_out  output  1  data_out is valid
- sof_out  output  1  current word is the header
- eof_out  output  1  current word is the last payload word
- ch_out  output  4  channel id of the current frame
- frame_cnt_out  output  16  total frames completed, wraps

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - FSM to IDLE; all outputs 0.
  - Per-channel INCR counters 0; per-channel LFSRs seeded ch+1; per-channel seq 0; channel pointer 0.
- Handshake:
  - A transfer occurs when valid_out && ready_in.
  - While valid_out && !ready_in, data_out, sof_out, eof_out and ch_out hold stable.
  - valid_out never drops without a transfer, except on reset.
- FSM states: IDLE, HEADER, PAYLOAD, GAP.
  - IDLE -> HEADER when enable_in=1. mode_in is sampled here and frozen for the whole frame.
  - HEADER: valid_out=1, sof_out=1. data_out = {zero pad, 8'hA5, 4'h0, ch[3:0], seq[15:0]}. On transfer -> PAYLOAD and word index cleared.
  - PAYLOAD: valid_out=1. eof_out=1 when index==BURST_LEN-1. On transfer, index increments and the channel's pattern state advances. On the last transfer:
    - seq[ch] increments (wraps at 16 bits) and frame_cnt_out increments.
    - Channel pointer advances (CH_N-1 wraps to 0).
    - Next state: GAP if GAP_CYC>0; else HEADER if enable_in=1; else IDLE.
  - GAP: valid_out=0 for exactly GAP_CYC cycles, then HEADER if enable_in=1, else IDLE.
- Payload modes (state kept per channel, persists across frames):
  - INCR: DATA_W counter; emits value then +1; wraps at 2^DATA_W.
  - LFSR: 32-bit Galois step using LFSR_POLY. Word = LFSR value replicated to DATA_W, truncated from the MSB side. An all-zero state is never reachable.
  - WALK: single one-hot bit, starts at bit 0, rotates left by one per word, wraps from DATA_W-1 to 0.
  - CONST: 8'hA5 replicated; no state advance.
- enable_in deassertion mid-frame: the current frame completes in full; the block then goes to IDLE.
- ready_in low for any duration: no state advance and no word loss.
- Latency: first header is valid on the cycle after enable_in is sampled high in IDLE.
- Peak throughput with ready_in held high: one word per cycle, no bubble between frames when GAP_CYC=0.

Optional Feature:
- Macro: STREAM_PATTERN_GEN_ERR_INJECT_EN
- Compiled in:
  - Extra input err_inject_in (1-bit pulse).
  - A pulse arms a one-shot. The next payload word transferred has bit 0 inverted on data_out. The pattern state is not affected.
  - If several pulses arrive while armed, only one word is corrupted.
  - The armed flag clears on reset.
- Compiled out: the port is absent and the output is never corrupted.

Decomposition:
- Shared package stream_pattern_gen_pkg holds:
  - mode encodings (MODE_INCR/LFSR/WALK/CONST)
  - FSM state encoding
  - HDR_MAGIC = 8'hA5 and CONST_BYTE = 8'hA5
  - default LFSR_POLY
- One sub-module, stream_lfsr_step: purely combinational next-state of the 32-bit Galois LFSR. It is instantiated once on the muxed current channel's state.

Test Plan:
- Reset/idle: rst_in=0 then 1, enable_in=0 for 20 cycles -> valid_out=0 and frame_cnt_out=0 throughout.
- INCR round-robin, CH_N=4, BURST_LEN=4, GAP_CYC=0, ready_in=1:
  - 8 frames -> headers on ch 0,1,2,3,0,1,2,3.
  - Header low half = seq 0 in the first round, seq 1 in the second.
  - ch0 payload 0,1,2,3 then 4,5,6,7.
  - frame_cnt_out = 8.
- Backpressure: randomly hold ready_in=0 for 1–7 cycles -> data_out/sof_out/eof_out stable while stalled, and the received stream is identical to the no-stall stream.
- GAP and enable drop, GAP_CYC=3:
  - 3 idle cycles appear between frames.
  - Drop enable_in at payload word 1 -> frame completes through eof_out, then IDLE with valid_out=0.
- Modes:
  - mode_in=2 -> payload 0x1, 0x2, 0x4, 0x8.
  - mode_in=3 -> 0xA5A5A5A5.
  - mode_in=1 on ch0 -> first word 0x00000001, second word equal to a reference-model Galois step.
  - Changing mode_in mid-frame has no effect until the next header.
- ERR_INJECT (macro defined): pulse err_inject_in during INCR ch0 -> exactly one payload word has bit 0 flipped (e.g. 0x00000005 emitted as 0x00000004); the following word is correct (0x00000006).
